// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants for the button input peripheral
package btn_pkg;

    // Default debounce window: 10 ms at 25 MHz.
    localparam int DEFAULT_CYCLES = 250000;

    // Register offsets from the peripheral base address.
    localparam logic [1:0] REG_LEVEL   = 2'd0;
    localparam logic [1:0] REG_PRESS   = 2'd1;
    localparam logic [1:0] REG_RELEASE = 2'd2;
    localparam logic [1:0] REG_MASK    = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - single-bit debouncer with rise/fall event pulses
//   clk, reset : clock, asynchronous active-high reset
//   in_sync    : already-synchronised input level
//   stable     : debounced level
//   rise, fall : one-cycle pulses, high in the cycle before stable changes
module btn_debounce
    import btn_pkg::*;
#(
    parameter int CYCLES = DEFAULT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic in_sync,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] count;
    logic          accept;

    // The accept decision looks at the current sample, so a toggle back on
    // the final count cycle is simply treated as "equal again" and dropped.
    assign accept = (in_sync != stable) && (count == LAST);
    assign rise   = accept && in_sync;
    assign fall   = accept && !in_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (in_sync == stable) begin
            count <= '0;
        end else if (count == LAST) begin
            stable <= in_sync;
            count  <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/btn_input.sv
// rtl/btn_input.sv - memory-mapped debounced button input with sticky events and irq
//   clk, reset : clock, asynchronous active-high reset
//   btn        : raw button levels, asynchronous to clk
//   strobe, rw : bus access qualifier, 1 = write
//   addr, d_in : bus word address, write data
//   d_out      : registered read data
//   irq        : level interrupt, |(PRESS & MASK)
module btn_input
    import btn_pkg::*;
#(
    parameter int          BITS   = 7,
    parameter int          CYCLES = DEFAULT_CYCLES,
    parameter logic [31:0] BASE   = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] btn,
    input  logic            strobe,
    input  logic            rw,
    input  logic [31:0]     addr,
    input  logic [31:0]     d_in,
    output logic [31:0]     d_out,
    output logic            irq
);

    logic [BITS-1:0] sync_meta;
    logic [BITS-1:0] sync_q;
    logic [BITS-1:0] level;
    logic [BITS-1:0] rise_v;
    logic [BITS-1:0] fall_v;
    logic [BITS-1:0] press_q;
    logic [BITS-1:0] release_q;
    logic [BITS-1:0] mask_q;
    logic [BITS-1:0] wr_bits;
    logic [BITS-1:0] press_clr;
    logic [BITS-1:0] release_clr;
    logic [31:0]     offset;
    logic [31:0]     rd_data;
    logic            hit;
    logic            wr_en;
    logic            rd_en;

    // Unsigned subtraction makes any address below BASE wrap to a large
    // offset, so a single compare covers both ends of the window.
    assign offset  = addr - BASE;
    assign hit     = (offset < 32'd4);
    assign wr_en   = strobe & rw & hit;
    assign rd_en   = strobe & ~rw & hit;
    assign wr_bits = d_in[BITS-1:0];

    generate
        if (BITS < 32) begin : g_pad
            logic unused_hi;
            assign unused_hi = ^d_in[31:BITS];
        end
    endgenerate

    assign press_clr   = (wr_en && offset[1:0] == REG_PRESS)   ? wr_bits : '0;
    assign release_clr = (wr_en && offset[1:0] == REG_RELEASE) ? wr_bits : '0;

    generate
        for (genvar i = 0; i < BITS; i++) begin : g_bit
            btn_debounce #(.CYCLES(CYCLES)) u_deb (
                .clk     (clk),
                .reset   (reset),
                .in_sync (sync_q[i]),
                .stable  (level[i]),
                .rise    (rise_v[i]),
                .fall    (fall_v[i])
            );
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        case (offset[1:0])
            REG_LEVEL:   rd_data[BITS-1:0] = level;
            REG_PRESS:   rd_data[BITS-1:0] = press_q;
            REG_RELEASE: rd_data[BITS-1:0] = release_q;
            REG_MASK:    rd_data[BITS-1:0] = mask_q;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            mask_q    <= '0;
            d_out     <= '0;
            irq       <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_q    <= sync_meta;
            // New events are OR-ed in after the clear, so a coincident
            // event keeps its bit set.
            press_q   <= (press_q & ~press_clr) | rise_v;
            release_q <= (release_q & ~release_clr) | fall_v;
            if (wr_en && offset[1:0] == REG_MASK) begin
                mask_q <= wr_bits;
            end
            if (rd_en) begin
                d_out <= rd_data;
            end
            irq <= |(press_q & mask_q);
        end
    end

endmodule

// File: tb/tb_btn_input.sv
// tb/tb_btn_input.sv - randomized and directed bench for btn_input against a history-window model
module tb_btn_input;

    localparam int          BITS   = 7;
    localparam int          CYCLES = 4;
    localparam logic [31:0] BASE   = 32'h100;

    logic            clk = 1'b0;
    logic            reset;
    logic [BITS-1:0] btn;
    logic            strobe;
    logic            rw;
    logic [31:0]     addr;
    logic [31:0]     d_in;
    logic [31:0]     d_out;
    logic            irq;

    always #5 clk = ~clk;

    btn_input #(.BITS(BITS), .CYCLES(CYCLES), .BASE(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn),
        .strobe (strobe),
        .rw     (rw),
        .addr   (addr),
        .d_in   (d_in),
        .d_out  (d_out),
        .irq    (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a button level is accepted once the synchronised value (raw
    // sample delayed by two edges) has differed from the stable level for
    // CYCLES consecutive edges. hist[k] is the raw sample taken k edges ago.
    logic [BITS-1:0] m_hist [1:CYCLES+1];
    logic [BITS-1:0] m_level   = '0;
    logic [BITS-1:0] m_press   = '0;
    logic [BITS-1:0] m_release = '0;
    logic [BITS-1:0] m_mask    = '0;
    logic [31:0]     m_dout    = '0;
    logic            m_irq     = 1'b0;

    function automatic logic [31:0] model_reg(input logic [31:0] off);
        logic [31:0] v;
        v = '0;
        if (off == 0) v[BITS-1:0] = m_level;
        else if (off == 1) v[BITS-1:0] = m_press;
        else if (off == 2) v[BITS-1:0] = m_release;
        else v[BITS-1:0] = m_mask;
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 1; k <= CYCLES + 1; k++) m_hist[k] = '0;
        m_level = '0; m_press = '0; m_release = '0; m_mask = '0;
        m_dout = '0; m_irq = 1'b0;
    endtask

    task automatic cycle();
        logic [BITS-1:0] c_btn, rise, fall;
        logic [31:0]     c_addr, c_din, off;
        logic            c_reset, c_strobe, c_rw, hit, diff;
        c_btn = btn; c_addr = addr; c_din = d_in;
        c_reset = reset; c_strobe = strobe; c_rw = rw;
        @(posedge clk);
        if (c_reset) begin
            model_clear();
        end else begin
            for (int i = 0; i < BITS; i++) begin
                diff = 1'b1;
                for (int k = 2; k <= CYCLES + 1; k++)
                    if (m_hist[k][i] == m_level[i]) diff = 1'b0;
                rise[i] = diff & ~m_level[i];
                fall[i] = diff & m_level[i];
            end
            hit = (c_addr >= BASE) && (c_addr <= BASE + 3);
            off = c_addr - BASE;
            if (c_strobe && !c_rw && hit) m_dout = model_reg(off);
            m_irq = |(m_press & m_mask);
            if (c_strobe && c_rw && hit) begin
                if (off == 1) m_press = m_press & ~c_din[BITS-1:0];
                if (off == 2) m_release = m_release & ~c_din[BITS-1:0];
                if (off == 3) m_mask = c_din[BITS-1:0];
            end
            m_press   = m_press | rise;
            m_release = m_release | fall;
            m_level   = m_level ^ (rise | fall);
            for (int k = CYCLES + 1; k >= 2; k--) m_hist[k] = m_hist[k-1];
            m_hist[1] = c_btn;
        end
        #1;
        check_eq("model_dout", d_out, m_dout);
        check_eq("model_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] data);
        strobe = 1'b1; rw = 1'b0; addr = a;
        cycle();
        strobe = 1'b0;
        data = d_out;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] data);
        strobe = 1'b1; rw = 1'b1; addr = a; d_in = data;
        cycle();
        strobe = 1'b0; rw = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        model_clear();
        reset = 1'b1; btn = '0; strobe = 1'b0; rw = 1'b0; addr = '0; d_in = '0;
        idle(3);
        check_eq("rst_dout", d_out, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;

        for (int r = 0; r < 4; r++) begin
            bus_read(BASE + 32'(r), v);
            check_eq("idle_read", v, 32'h0);
        end
        check_eq("idle_irq", 32'(irq), 32'h0);

        // Hold btn[2]; stable changes on the sixth edge after the change.
        btn = 7'h04;
        idle(5);
        bus_read(32'h100, v); check_eq("level_not_early", v, 32'h0);
        bus_read(32'h100, v); check_eq("level_set", v, 32'h4);
        bus_read(32'h101, v); check_eq("press_set", v, 32'h4);
        bus_read(32'h102, v); check_eq("release_clear", v, 32'h0);
        check_eq("irq_masked", 32'(irq), 32'h0);

        bus_write(32'h103, 32'h4);
        check_eq("irq_lag", 32'(irq), 32'h0);
        idle(1);
        check_eq("irq_on", 32'(irq), 32'h1);
        bus_write(32'h101, 32'h4);
        check_eq("irq_hold", 32'(irq), 32'h1);
        idle(1);
        check_eq("irq_off", 32'(irq), 32'h0);
        bus_read(32'h101, v); check_eq("press_w1c", v, 32'h0);
        btn = 7'h00;
        idle(7);
        bus_read(32'h102, v); check_eq("release_set", v, 32'h4);
        bus_read(32'h100, v); check_eq("level_clear", v, 32'h0);
        check_eq("irq_release", 32'(irq), 32'h0);

        // Three-cycle glitch is shorter than the window.
        btn = 7'h01;
        idle(3);
        btn = 7'h00;
        idle(8);
        bus_read(32'h100, v); check_eq("glitch_level", v, 32'h0);
        bus_read(32'h101, v); check_eq("glitch_press", v, 32'h0);

        // W1C on the same edge as the bit-1 rise: the set must win.
        btn = 7'h02;
        idle(5);
        bus_write(32'h101, 32'h2);
        bus_read(32'h101, v); check_eq("set_beats_w1c", v, 32'h2);
        bus_write(32'h101, 32'h7f);
        btn = 7'h00;
        idle(8);
        bus_write(32'h102, 32'h7f);

        // Reset mid-debounce with btn[5] held.
        bus_write(32'h103, 32'h7f);
        btn = 7'h20;
        idle(4);
        reset = 1'b1;
        #1;
        check_eq("async_rst_irq", 32'(irq), 32'h0);
        idle(1);
        reset = 1'b0;
        bus_read(32'h100, v); check_eq("post_rst_level", v, 32'h0);
        bus_read(32'h101, v); check_eq("post_rst_press", v, 32'h0);
        bus_read(32'h102, v); check_eq("post_rst_release", v, 32'h0);
        bus_read(32'h103, v); check_eq("post_rst_mask", v, 32'h0);
        idle(1);
        bus_read(32'h101, v); check_eq("rst_press_not_early", v, 32'h0);
        bus_read(32'h101, v); check_eq("rst_press_set", v, 32'h20);

        // Out-of-window writes and LEVEL writes change nothing.
        bus_write(32'h104, 32'hffffffff);
        bus_write(32'h105, 32'hffffffff);
        bus_write(32'h107, 32'hffffffff);
        bus_write(32'h0ff, 32'hffffffff);
        bus_write(32'h100, 32'hffffffff);
        bus_read(32'h103, v); check_eq("oow_mask", v, 32'h0);
        bus_read(32'h101, v); check_eq("oow_press", v, 32'h20);
        bus_read(32'h100, v); check_eq("oow_level", v, 32'h20);
        bus_read(32'h104, v); check_eq("oow_read_holds", v, 32'h20);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < BITS; i++)
                if ($urandom_range(7) == 0) btn[i] = ~btn[i];
            strobe = 1'($urandom_range(1));
            rw     = 1'($urandom_range(1));
            addr   = 32'hfe + 32'($urandom_range(7));
            d_in   = $urandom;
            reset  = ($urandom_range(399) == 0);
            cycle();
        end
        reset = 1'b0; strobe = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
